// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl
// Sequencing controller for a WIDTH-bit D-flip-flop shift/LFSR register bank.
// It seeds the bank, steps it either until the bank returns to its seed
// (FREE, period measurement) or for a fixed number of shifts (COUNT). It also
// keeps a shadow copy of the expected bank contents so a faulty bank is caught
// in-system. Every state update happens on the falling clock edge, the same
// edge the bank uses, so dp_load/dp_shift act on the edge that ends the cycle
// in which they are asserted.
//
// Handshake: start is sampled only in IDLE, and only when abort is low.
// busy is high while the controller owns the bank (LOAD and RUN). Completion
// is a single-cycle done pulse with busy low. An error parks the controller
// in ERR (err=1, err_code valid) until abort returns it to IDLE. A start seen
// in any state other than IDLE is ignored, not queued.
module lfsr_seq_ctrl #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(4'b0011),
    parameter int               CNT_W     = 8,
    parameter int               MAX_STEPS = 255
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [CNT_W-1:0] n_steps,
    input  logic             hold,
    input  logic             abort,
    input  logic [WIDTH-1:0] dp_q,
    output logic             dp_load,
    output logic [WIDTH-1:0] dp_seed,
    output logic             dp_shift,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] period,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic       MODE_FREE    = 1'b0;
    localparam logic       MODE_COUNT   = 1'b1;
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ZERO     = 2'b01;
    localparam logic [1:0] ERR_MISMATCH = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // The timeout fires at MAX_CNT, so step_q can never wrap.
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] nsteps_q, nsteps_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             shift_en;

    // One bank step: new MSB is the parity of the tapped bits, the rest shift right.
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
        return {^(x & TAPS), x[WIDTH-1:1]};
    endfunction

    // Completion conditions for the two run modes, evaluated on the live bank value.
    logic free_hit;
    logic count_hit;
    logic free_timeout;
    assign free_hit     = (mode_q == MODE_FREE) && (step_q != '0) && (dp_q == seed_q);
    assign count_hit    = (mode_q == MODE_COUNT) && (step_q == nsteps_q);
    assign free_timeout = (mode_q == MODE_FREE) && (step_q == MAX_CNT);

    // Next-state and datapath control; abort beats everything, then the
    // shadow mismatch check, then completion, then timeout, then shifting.
    always_comb begin
        state_d    = state_q;
        seed_d     = seed_q;
        mode_d     = mode_q;
        nsteps_d   = nsteps_q;
        exp_d      = exp_q;
        step_d     = step_q;
        period_d   = period_q;
        err_code_d = err_code_q;
        shift_en   = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        seed_d     = seed_in;
                        mode_d     = mode;
                        nsteps_d   = n_steps;
                        period_d   = '0;
                        err_code_d = ERR_NONE;
                        if (seed_in == '0) begin
                            // An all-zero seed would lock the bank at zero.
                            state_d    = S_ERR;
                            err_code_d = ERR_ZERO;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    exp_d   = seed_q;
                    step_d  = '0;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (dp_q != exp_q) begin
                        state_d    = S_ERR;
                        err_code_d = ERR_MISMATCH;
                    end else if (free_hit || count_hit) begin
                        // No shift on this edge: the bank rests on the final value.
                        period_d = step_q;
                        state_d  = S_DONE;
                    end else if (free_timeout) begin
                        state_d    = S_ERR;
                        err_code_d = ERR_TIMEOUT;
                    end else if (!hold) begin
                        shift_en = 1'b1;
                        exp_d    = lfsr_next(exp_q);
                        step_d   = step_q + CNT_ONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Falling-edge state register with asynchronous active-low clear.
    always_ff @(negedge clk or negedge clear) begin
        if (!clear) begin
            state_q    <= S_IDLE;
            seed_q     <= '0;
            mode_q     <= 1'b0;
            nsteps_q   <= '0;
            exp_q      <= '0;
            step_q     <= '0;
            period_q   <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            seed_q     <= seed_d;
            mode_q     <= mode_d;
            nsteps_q   <= nsteps_d;
            exp_q      <= exp_d;
            step_q     <= step_d;
            period_q   <= period_d;
            err_code_q <= err_code_d;
        end
    end

    // Moore outputs decoded from the state register; dp_shift is the only
    // combinational control so the bank can be frozen in the same cycle.
    assign dp_load   = (state_q == S_LOAD);
    assign dp_seed   = seed_q;
    assign dp_shift  = shift_en;
    assign busy      = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);
    assign err_code  = err_code_q;
    assign period    = period_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl. Two controllers share all control inputs:
// instance A drives an ideal (optionally Q2-stuck) bank with TAPS=0011,
// instance B drives an ideal bank with TAPS=0000, which never returns to a
// nonzero seed and so exercises the FREE timeout. Both use MAX_STEPS=20.
module tb_lfsr_seq_ctrl;

    localparam int         MAXS   = 20;
    localparam logic [3:0] TAPS_A = 4'b0011;
    localparam logic [3:0] TAPS_B = 4'b0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    logic       start, mode, hold, abort;
    logic [3:0] seed_in;
    logic [7:0] n_steps;

    logic [3:0] bank_a, dpq_a, seed_a;
    logic       load_a, shift_a, busy_a, done_a, err_a;
    logic [1:0] code_a;
    logic [7:0] period_a;
    logic [2:0] dbg_a;

    logic [3:0] bank_b, dpq_b, seed_b;
    logic       load_b, shift_b, busy_b, done_b, err_b;
    logic [1:0] code_b;
    logic [7:0] period_b;
    logic [2:0] dbg_b;

    logic stuck_q2;

    lfsr_seq_ctrl #(.WIDTH(4), .TAPS(TAPS_A), .CNT_W(8), .MAX_STEPS(MAXS)) u_dut (
        .clk(clk), .clear(clear), .start(start), .mode(mode), .seed_in(seed_in),
        .n_steps(n_steps), .hold(hold), .abort(abort), .dp_q(dpq_a),
        .dp_load(load_a), .dp_seed(seed_a), .dp_shift(shift_a), .busy(busy_a),
        .done(done_a), .err(err_a), .err_code(code_a), .period(period_a),
        .state_dbg(dbg_a)
    );

    lfsr_seq_ctrl #(.WIDTH(4), .TAPS(TAPS_B), .CNT_W(8), .MAX_STEPS(MAXS)) u_dut_b (
        .clk(clk), .clear(clear), .start(start), .mode(mode), .seed_in(seed_in),
        .n_steps(n_steps), .hold(hold), .abort(abort), .dp_q(dpq_b),
        .dp_load(load_b), .dp_seed(seed_b), .dp_shift(shift_b), .busy(busy_b),
        .done(done_b), .err(err_b), .err_code(code_b), .period(period_b),
        .state_dbg(dbg_b)
    );

    // Reference step: shift right by one, MSB becomes the parity of the tapped bits.
    function automatic logic [3:0] lfsr_step(input logic [3:0] x, input logic [3:0] taps);
        logic [3:0] r;
        r = x >> 1;
        if (($countones(x & taps) % 2) == 1) r = r + 4'd8;
        return r;
    endfunction

    // Bank models (falling edge, like the real register bank).
    always @(negedge clk or negedge clear) begin
        if (!clear) bank_a <= '0;
        else if (load_a) bank_a <= seed_a;
        else if (shift_a) bank_a <= lfsr_step(bank_a, TAPS_A);
    end
    assign dpq_a = stuck_q2 ? (bank_a & 4'b1011) : bank_a;

    always @(negedge clk or negedge clear) begin
        if (!clear) bank_b <= '0;
        else if (load_b) bank_b <= seed_b;
        else if (shift_b) bank_b <= lfsr_step(bank_b, TAPS_B);
    end
    assign dpq_b = bank_b;

    // Instance under observation.
    logic       sel_b;
    logic [3:0] cur_q;
    logic       cur_load, cur_shift, cur_busy, cur_done, cur_err;
    logic [1:0] cur_code;
    logic [7:0] cur_period;
    always_comb begin
        cur_q      = sel_b ? dpq_b : dpq_a;
        cur_load   = sel_b ? load_b : load_a;
        cur_shift  = sel_b ? shift_b : shift_a;
        cur_busy   = sel_b ? busy_b : busy_a;
        cur_done   = sel_b ? done_b : done_a;
        cur_err    = sel_b ? err_b : err_a;
        cur_code   = sel_b ? code_b : code_a;
        cur_period = sel_b ? period_b : period_a;
    end

    // ---------------- scoreboard ----------------
    logic [3:0] exp_q[$];   // expected bank value at each shift, from the model
    logic [3:0] obs_q[$];   // observed bank value at each shift
    int n_vec = 0;
    int n_err = 0;
    int shift_cnt, load_cnt, done_cnt, hold_shift_cnt, busy_gap;
    logic run_active, end_flag;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock: observe mid-high-phase (controls for the coming falling
    // edge are stable), then return just after the falling edge.
    task automatic tick();
        logic [3:0] e;
        @(posedge clk);
        #1;
        if (cur_shift) begin
            shift_cnt++;
            obs_q.push_back(cur_q);
            if (hold) hold_shift_cnt++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("sb_shift_state", 32'(cur_q), 32'(e));
            end
        end
        if (cur_load) load_cnt++;
        if (cur_done) done_cnt++;
        if (run_active) begin
            if (cur_done || cur_err) end_flag = 1'b1;
            else if (!cur_busy) busy_gap++;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic clr_counts();
        shift_cnt = 0; load_cnt = 0; done_cnt = 0; hold_shift_cnt = 0; busy_gap = 0;
        end_flag = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    // One complete transaction against the selected instance, with random
    // hold and random start/seed/mode/n_steps noise while it runs.
    task automatic run_txn(input logic [3:0] s, input logic m, input logic [7:0] n,
                           input int hold_pct, input logic use_b, input logic fault);
        logic [3:0] taps, mask, x, fin;
        logic       exp_done;
        logic [1:0] exp_code;
        logic [7:0] exp_period;
        int         k, exp_shifts;
        bit         stop;

        sel_b = use_b; hold = 1'b0; start = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        stuck_q2 = fault;
        clr_counts();

        // Reference: walk the bank values produced by the stepping rules.
        taps = use_b ? TAPS_B : TAPS_A;
        mask = fault ? 4'b1011 : 4'b1111;
        exp_done = 1'b0; exp_code = 2'b00; exp_period = 8'd0; fin = 4'd0;
        if (s == 4'd0) begin
            exp_code = 2'b01;
        end else begin
            x = s; k = 0; stop = 0;
            while (!stop) begin
                if ((x & mask) != x) begin exp_code = 2'b10; stop = 1; end
                else if (m && k == int'(n)) begin exp_done = 1; exp_period = 8'(k); stop = 1; end
                else if (!m && k != 0 && x == s) begin exp_done = 1; exp_period = 8'(k); stop = 1; end
                else if (!m && k == MAXS) begin exp_code = 2'b11; stop = 1; end
                else begin exp_q.push_back(x); x = lfsr_step(x, taps); k++; end
            end
            fin = x & mask;
        end
        exp_shifts = exp_q.size();

        seed_in = s; mode = m; n_steps = n; start = 1'b1;
        tick();
        start = 1'b0; run_active = 1'b1;
        for (int c = 0; c < 600 && !end_flag; c++) begin
            hold    = ($urandom_range(99) < hold_pct);
            start   = ($urandom_range(9) == 0);
            seed_in = 4'($urandom);
            mode    = 1'($urandom);
            n_steps = 8'($urandom);
            tick();
        end
        run_active = 1'b0; hold = 1'b0; start = 1'b0;
        tick();
        tick();

        check_eq("end_seen", 32'(end_flag), 32'd1);
        check_eq("done_pulses", 32'(done_cnt), 32'(exp_done));
        check_eq("err_flag", 32'(cur_err), 32'(!exp_done));
        check_eq("err_code", 32'(cur_code), 32'(exp_code));
        check_eq("period", 32'(cur_period), 32'(exp_period));
        check_eq("shift_count", 32'(shift_cnt), 32'(exp_shifts));
        check_eq("load_count", 32'(load_cnt), 32'(s != 4'd0));
        check_eq("shift_in_hold", 32'(hold_shift_cnt), 32'd0);
        check_eq("busy_gap", 32'(busy_gap), 32'd0);
        check_eq("busy_after", 32'(cur_busy), 32'd0);
        if (s != 4'd0) check_eq("final_q", 32'(cur_q), 32'(fin));
    endtask

    logic [3:0] free_tab [15] = '{4'b1000, 4'b0100, 4'b0010, 4'b1001, 4'b1100,
                                  4'b0110, 4'b1011, 4'b0101, 4'b1010, 4'b1101,
                                  4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
    logic [3:0] snap_q;
    int         snap_cnt;
    logic [3:0] rs;
    logic       rm, rb;
    logic [7:0] rn;

    // ---------------- main sequence ----------------
    initial begin
        clear = 1'b1; start = 1'b0; mode = 1'b0; hold = 1'b0; abort = 1'b0;
        seed_in = 4'd0; n_steps = 8'd0; stuck_q2 = 1'b0; sel_b = 1'b0;
        run_active = 1'b0;
        clr_counts();

        // Reset state
        #2 clear = 1'b0;
        #1;
        check_eq("rst_load", 32'(load_a), 32'd0);
        check_eq("rst_shift", 32'(shift_a), 32'd0);
        check_eq("rst_seed", 32'(seed_a), 32'd0);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_done", 32'(done_a), 32'd0);
        check_eq("rst_err", 32'(err_a), 32'd0);
        check_eq("rst_code", 32'(code_a), 32'd0);
        check_eq("rst_period", 32'(period_a), 32'd0);
        #4 clear = 1'b1;
        @(negedge clk);
        #1;

        // FREE from 1000 on an ideal bank: full 15-state cycle.
        run_txn(4'b1000, 1'b0, 8'd0, 0, 1'b0, 1'b0);
        check_eq("free_len", 32'(obs_q.size()), 32'd15);
        for (int i = 0; i < 15 && i < obs_q.size(); i++)
            check_eq("free_seq", 32'(obs_q[i]), 32'(free_tab[i]));
        check_eq("free_period", 32'(period_a), 32'd15);
        check_eq("free_rest", 32'(dpq_a), 32'b1000);

        // COUNT 3 shifts, then abort in IDLE keeps the period.
        run_txn(4'b1000, 1'b1, 8'd3, 0, 1'b0, 1'b0);
        check_eq("cnt3_q", 32'(dpq_a), 32'b1001);
        check_eq("cnt3_shifts", 32'(shift_cnt), 32'd3);
        abort = 1'b1; tick(); abort = 1'b0;
        check_eq("abort_keeps_period", 32'(period_a), 32'd3);

        // COUNT zero shifts.
        run_txn(4'b1000, 1'b1, 8'd0, 0, 1'b0, 1'b0);
        check_eq("cnt0_shifts", 32'(shift_cnt), 32'd0);

        // Zero seed, then abort back to IDLE.
        run_txn(4'b0000, 1'b0, 8'd0, 0, 1'b0, 1'b0);
        check_eq("zero_code", 32'(code_a), 32'b01);
        abort = 1'b1; tick(); abort = 1'b0;
        check_eq("zero_abort_err", 32'(err_a), 32'd0);

        // Q2 stuck-at-0 after loading 1100: mismatch, no shifting afterwards.
        run_txn(4'b1100, 1'b0, 8'd0, 0, 1'b0, 1'b1);
        check_eq("stuck_code", 32'(code_a), 32'b10);
        shift_cnt = 0;
        repeat (4) tick();
        check_eq("stuck_no_shift", 32'(shift_cnt), 32'd0);
        stuck_q2 = 1'b0;

        // FREE timeout on the bank that never returns to its seed.
        run_txn(4'b1000, 1'b0, 8'd0, 0, 1'b1, 1'b0);
        check_eq("tmo_code", 32'(code_b), 32'b11);
        check_eq("tmo_shifts", 32'(shift_cnt), 32'd20);

        // Hold for 5 cycles mid-run, then abort.
        sel_b = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
        clr_counts();
        seed_in = 4'b1001; mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        check_eq("pre_hold_shifts", 32'(shift_cnt), 32'd3);
        hold = 1'b1; snap_q = dpq_a; snap_cnt = shift_cnt;
        repeat (5) tick();
        check_eq("hold_q", 32'(dpq_a), 32'(snap_q));
        check_eq("hold_cnt", 32'(shift_cnt), 32'(snap_cnt));
        check_eq("hold_busy", 32'(busy_a), 32'd1);
        hold = 1'b0; tick();
        check_eq("post_hold_shift", 32'(shift_cnt), 32'(snap_cnt + 1));
        abort = 1'b1; tick(); abort = 1'b0;
        check_eq("abort_busy", 32'(busy_a), 32'd0);
        check_eq("abort_err", 32'(err_a), 32'd0);
        check_eq("abort_period", 32'(period_a), 32'd0);
        check_eq("abort_shift", 32'(shift_a), 32'd0);

        // Asynchronous clear mid-run.
        seed_in = 4'b1000; mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        #2;
        check_eq("pre_clear_shift", 32'(shift_a), 32'd1);
        clear = 1'b0;
        #1;
        check_eq("clr_load", 32'(load_a), 32'd0);
        check_eq("clr_shift", 32'(shift_a), 32'd0);
        check_eq("clr_seed", 32'(seed_a), 32'd0);
        check_eq("clr_busy", 32'(busy_a), 32'd0);
        check_eq("clr_done", 32'(done_a), 32'd0);
        check_eq("clr_err", 32'(err_a), 32'd0);
        check_eq("clr_code", 32'(code_a), 32'd0);
        check_eq("clr_period", 32'(period_a), 32'd0);
        @(posedge clk);
        #1 clear = 1'b1;
        @(negedge clk);
        #1;
        check_eq("clr_idle", 32'(busy_a), 32'd0);

        // Randomized transactions against the reference walk.
        for (int t = 0; t < 24; t++) begin
            rs = 4'($urandom_range(0, 15));
            rm = 1'($urandom_range(0, 1));
            rn = 8'($urandom_range(0, 30));
            rb = ($urandom_range(0, 3) == 0);
            run_txn(rs, rm, rn, $urandom_range(0, 40), rb, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
